// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: access-size codes, FSM states
// and the byte-lane count helper.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        RESP
    } state_e;

    function automatic int nb(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_extract.sv
// Load-side lane select: picks the addressed big-endian lane out of the read
// word and sign- or zero-extends it to the full bus width.
module lane_extract
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB = nb(DATA_W),
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF_W-1:0]  offset,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] top_bit;
    logic              sign;
    int                sh;
    int                w;

    always_comb begin
        w = 8 << size;
        // Offset 0 is the most significant lane, so the field sits w bits below
        // the top of the bus, shifted down further by 8 bits per byte offset.
        sh = (DATA_W - w) - 8 * int'(offset);
        if (sh < 0) begin
            sh = 0;
        end
        shifted = rdata >> sh;
        mask    = (w >= DATA_W) ? '1 : ~({DATA_W{1'b1}} << w);
        top_bit = mask & ~(mask >> 1);
        sign    = |(shifted & top_bit);
        data    = shifted & mask;
        if (!is_unsigned && sign) begin
            data = data | ~mask;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline memory-stage access unit: aligns and lane-replicates stores, extracts
// and extends loads, and sequences the memory handshake with flush support.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  req_ready,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_data,
    output logic                  resp_err,
    output logic                  stall
);

    localparam int NB    = nb(DATA_W);
    localparam int OFF_W = $clog2(NB);

    state_e              state_reg, state_next;
    logic                we_reg;
    logic [1:0]          size_reg;
    logic                unsigned_reg;
    logic [OFF_W-1:0]    off_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [NB-1:0]       be_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   resp_data_reg;
    logic                resp_err_reg;

    logic [OFF_W-1:0]    req_off;
    logic [3:0]          req_bytes;
    logic                size_ok;
    logic                aligned;
    logic                req_bad;
    logic [NB-1:0]       req_top;
    logic [NB-1:0]       req_be;
    logic [DATA_W-1:0]   req_rep;
    logic [DATA_W-1:0]   load_data;
    logic                in_access;

    always_comb begin
        req_off   = req_addr[OFF_W-1:0];
        req_bytes = 4'd1 << req_size;
        size_ok   = (req_size != SIZE_DWORD) || (DATA_W == 64);
        case (req_size)
            SIZE_BYTE: aligned = 1'b1;
            SIZE_HALF: aligned = ~req_addr[0];
            SIZE_WORD: aligned = (req_addr[1:0] == 2'b00);
            default:   aligned = (req_addr[2:0] == 3'b000);
        endcase
        req_bad = ~size_ok | ~aligned;

        // Strobes: a run of req_bytes ones starting at the top lane, moved down by the offset.
        req_top = ~({NB{1'b1}} >> req_bytes);
        req_be  = req_we ? (req_top >> req_off) : '0;

        case (req_size)
            SIZE_BYTE: req_rep = {NB{req_wdata[7:0]}};
            SIZE_HALF: req_rep = {(NB/2){req_wdata[15:0]}};
            SIZE_WORD: req_rep = {(NB/4){req_wdata[31:0]}};
            default:   req_rep = req_wdata;
        endcase
        if (!req_we) begin
            req_rep = '0;
        end
    end

    lane_extract #(
        .DATA_W(DATA_W)
    ) u_lane_extract (
        .rdata       (mem_rdata),
        .offset      (off_reg),
        .size        (size_reg),
        .is_unsigned (unsigned_reg),
        .data        (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        resp_valid = 1'b0;
        in_access  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_bad ? RESP : ISSUE;
                end
            end
            ISSUE, WAIT: begin
                mem_req   = 1'b1;
                in_access = 1'b1;
                if (mem_ack) begin
                    state_next = flush ? IDLE : RESP;
                end else if (flush) begin
                    state_next = DRAIN;
                end else begin
                    state_next = WAIT;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_reg        <= 1'b0;
            size_reg      <= 2'd0;
            unsigned_reg  <= 1'b0;
            off_reg       <= '0;
            addr_reg      <= '0;
            be_reg        <= '0;
            wdata_reg     <= '0;
            resp_data_reg <= '0;
            resp_err_reg  <= 1'b0;
        end else if (state_reg == IDLE && req_valid) begin
            we_reg        <= req_we;
            size_reg      <= req_size;
            unsigned_reg  <= req_unsigned;
            off_reg       <= req_off;
            addr_reg      <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            be_reg        <= req_bad ? '0 : req_be;
            wdata_reg     <= req_rep;
            resp_data_reg <= '0;
            resp_err_reg  <= req_bad;
        end else if (in_access && mem_ack && !flush) begin
            resp_data_reg <= we_reg ? '0 : load_data;
        end
    end

    assign mem_be    = be_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign resp_data = resp_data_reg;
    assign resp_err  = resp_err_reg;
    assign stall     = req_valid & ~req_ready;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: 32-bit and 64-bit instances, expected
// responses queued at request time and compared when resp_valid appears.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_we, req_unsigned, flush, mem_ack;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, mem_rdata;
    logic        req_ready, mem_req, resp_valid, resp_err, stall;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, resp_data;

    logic        req_valid_64, req_we_64, req_unsigned_64, flush_64, mem_ack_64;
    logic [1:0]  req_size_64;
    logic [31:0] req_addr_64;
    logic [63:0] req_wdata_64, mem_rdata_64;
    logic        req_ready_64, mem_req_64, resp_valid_64, resp_err_64, stall_64;
    logic [7:0]  mem_be_64;
    logic [31:0] mem_addr_64;
    logic [63:0] mem_wdata_64, resp_data_64;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total = 0;
    int   resp_seen = 0;

    always @(negedge clk) if (resp_valid === 1'b1) resp_seen++;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .flush(flush), .mem_req(mem_req), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err), .stall(stall)
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rst(rst), .req_valid(req_valid_64), .req_we(req_we_64), .req_size(req_size_64),
        .req_unsigned(req_unsigned_64), .req_addr(req_addr_64), .req_wdata(req_wdata_64),
        .req_ready(req_ready_64), .flush(flush_64), .mem_req(mem_req_64), .mem_be(mem_be_64),
        .mem_addr(mem_addr_64), .mem_wdata(mem_wdata_64), .mem_ack(mem_ack_64), .mem_rdata(mem_rdata_64),
        .resp_valid(resp_valid_64), .resp_data(resp_data_64), .resp_err(resp_err_64), .stall(stall_64)
    );

    task automatic test_reset;
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || mem_req !== 1'b0 || resp_valid !== 1'b0 || stall !== 1'b0)
            $display("FAIL reset_ctrl act ready=%b mem_req=%b resp_valid=%b stall=%b exp 1/0/0/0", req_ready, mem_req, resp_valid, stall);
        else passed++;
        total++; if (mem_be !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
            $display("FAIL reset_mem act be=%h addr=%h wdata=%h exp 0/0/0", mem_be, mem_addr, mem_wdata);
        else passed++;
        total++; if (resp_data !== 32'h0 || resp_err !== 1'b0 || req_ready_64 !== 1'b1 || mem_be_64 !== 8'h0)
            $display("FAIL reset_resp act data=%h err=%b ready64=%b be64=%h exp 0/0/1/0", resp_data, resp_err, req_ready_64, mem_be_64);
        else passed++;
    endtask

    // One complete request on the 32-bit instance; delay = cycles without ack before the ack cycle.
    task automatic do_req(input string name, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int delay,
                          input logic [31:0] rdata, input logic hold, input logic [3:0] exp_be,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || stall !== 1'b0) $display("FAIL %s accept act ready=%b stall=%b exp 1/0", name, req_ready, stall);
        else passed++;
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        sb.push_back('{data: {32'h0, exp_data}, err: exp_err});
        if (!exp_err) begin
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                total++; if (mem_req !== 1'b1 || (hold && stall !== 1'b1) || mem_addr !== exp_addr)
                    $display("FAIL %s wait%0d act mem_req=%b stall=%b addr=%h exp 1/%b/%h", name, i, mem_req, stall, mem_addr, hold, exp_addr);
                else passed++;
                @(posedge clk); #1;
            end
            mem_ack = 1'b1; mem_rdata = rdata;
            @(negedge clk);
            total++; if (mem_req !== 1'b1) $display("FAIL %s mem_req act=%b exp=1", name, mem_req);
            else passed++;
            total++; if (mem_be !== exp_be || mem_addr !== exp_addr || mem_wdata !== exp_wdata)
                $display("FAIL %s mem_bus act be=%h addr=%h wdata=%h exp %h/%h/%h", name, mem_be, mem_addr, mem_wdata, exp_be, exp_addr, exp_wdata);
            else passed++;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = 32'h0;
        end
        @(negedge clk);
        req_valid = 1'b0;
        total++; if (mem_req !== 1'b0 || resp_valid !== 1'b1) $display("FAIL %s resp act mem_req=%b resp_valid=%b exp 0/1", name, mem_req, resp_valid);
        else passed++;
        e = sb.pop_front();
        total++; if (resp_data !== e.data[31:0] || resp_err !== e.err)
            $display("FAIL %s resp_data act data=%h err=%b exp %h/%b", name, resp_data, resp_err, e.data[31:0], e.err);
        else passed++;
        @(negedge clk);
        total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL %s after act resp_valid=%b ready=%b exp 0/1", name, resp_valid, req_ready);
        else passed++;
    endtask

    task automatic do_req64(input string name, input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                            input logic [7:0] exp_be, input logic [31:0] exp_addr, input logic [63:0] exp_wdata,
                            input logic [63:0] exp_data);
        exp_t e;
        @(posedge clk); #1;
        req_valid_64 = 1'b1; req_we_64 = we; req_size_64 = size; req_unsigned_64 = uns; req_addr_64 = addr; req_wdata_64 = wdata;
        @(posedge clk); #1;
        req_valid_64 = 1'b0; mem_ack_64 = 1'b1; mem_rdata_64 = rdata;
        sb.push_back('{data: exp_data, err: 1'b0});
        @(negedge clk);
        total++; if (mem_req_64 !== 1'b1 || mem_be_64 !== exp_be || mem_addr_64 !== exp_addr || mem_wdata_64 !== exp_wdata)
            $display("FAIL %s mem_bus act req=%b be=%h addr=%h wdata=%h exp 1/%h/%h/%h", name, mem_req_64, mem_be_64, mem_addr_64, mem_wdata_64, exp_be, exp_addr, exp_wdata);
        else passed++;
        @(posedge clk); #1;
        mem_ack_64 = 1'b0; mem_rdata_64 = 64'h0;
        @(negedge clk);
        e = sb.pop_front();
        total++; if (resp_valid_64 !== 1'b1 || resp_data_64 !== e.data || resp_err_64 !== e.err)
            $display("FAIL %s resp act valid=%b data=%h err=%b exp 1/%h/%b", name, resp_valid_64, resp_data_64, resp_err_64, e.data, e.err);
        else passed++;
    endtask

    task automatic test_flush;
        int seen0;
        seen0 = resp_seen;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h4; req_wdata = 32'h0;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        total++; if (mem_req !== 1'b0 || req_ready !== 1'b0) $display("FAIL flush_drain act mem_req=%b ready=%b exp 0/0", mem_req, req_ready);
        else passed++;
        @(posedge clk); #1;
        @(posedge clk); #1; mem_ack = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b0) $display("FAIL flush_ack_cycle act ready=%b exp 0", req_ready);
        else passed++;
        @(posedge clk); #1; mem_ack = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || resp_seen !== seen0) $display("FAIL flush_done act ready=%b resps=%0d exp 1/%0d", req_ready, resp_seen, seen0);
        else passed++;
    endtask

    task automatic test_flush_with_ack;
        int seen0;
        seen0 = resp_seen;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h7; req_wdata = 32'h3C;
        @(posedge clk); #1; req_valid = 1'b0; flush = 1'b1; mem_ack = 1'b1;
        @(posedge clk); #1; flush = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || mem_req !== 1'b0) $display("FAIL flush_ack act ready=%b mem_req=%b exp 1/0", req_ready, mem_req);
        else passed++;
        @(negedge clk);
        total++; if (resp_seen !== seen0) $display("FAIL flush_ack_noresp act resps=%0d exp %0d", resp_seen, seen0);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int seen0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd1; req_addr = 32'h2;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1 || mem_req !== 1'b0) $display("FAIL reset_async act ready=%b mem_req=%b exp 1/0", req_ready, mem_req);
        else passed++;
        @(negedge clk); rst = 1'b0;
        seen0 = resp_seen;
        @(posedge clk); #1; mem_ack = 1'b1;
        @(posedge clk); #1; mem_ack = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || mem_req !== 1'b0 || resp_seen !== seen0)
            $display("FAIL stray_ack act ready=%b mem_req=%b resps=%0d exp 1/0/%0d", req_ready, mem_req, resp_seen, seen0);
        else passed++;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        flush = 0; mem_ack = 0; mem_rdata = 0;
        req_valid_64 = 0; req_we_64 = 0; req_size_64 = 0; req_unsigned_64 = 0; req_addr_64 = 0; req_wdata_64 = 0;
        flush_64 = 0; mem_ack_64 = 0; mem_rdata_64 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        //      name            we  sz    uns   addr      wdata         dly rdata         hold be     addr      wdata         data          err
        do_req("store_byte",   1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 0, 32'h0,        0, 4'b0001, 32'h10, 32'hA5A5A5A5, 32'h0,        0);
        do_req("load_half_s",  0, 2'd1, 1'b0, 32'h22, 32'h0,        0, 32'h1234F00D, 0, 4'b0000, 32'h20, 32'h0,        32'hFFFFF00D, 0);
        do_req("load_half_u",  0, 2'd1, 1'b1, 32'h22, 32'h0,        0, 32'h1234F00D, 0, 4'b0000, 32'h20, 32'h0,        32'h0000F00D, 0);
        do_req("load_misalgn", 0, 2'd2, 1'b0, 32'h02, 32'h0,        0, 32'h0,        0, 4'b0000, 32'h0,  32'h0,        32'h0,        1);
        do_req("load_stall",   0, 2'd0, 1'b0, 32'h01, 32'h0,        5, 32'h00800000, 1, 4'b0000, 32'h00, 32'h0,        32'hFFFFFF80, 0);
        do_req("store_half",   1, 2'd1, 1'b0, 32'h06, 32'h0000BEEF, 0, 32'h0,        0, 4'b0011, 32'h04, 32'hBEEFBEEF, 32'h0,        0);
        do_req("store_word",   1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, 2, 32'h0,        0, 4'b1111, 32'h08, 32'hDEADBEEF, 32'h0,        0);
        do_req("load_byte_u",  0, 2'd0, 1'b1, 32'h1C, 32'h0,        1, 32'h9ABCDEF0, 0, 4'b0000, 32'h1C, 32'h0,        32'h0000009A, 0);
        do_req("store_misalg", 1, 2'd1, 1'b0, 32'h03, 32'h00001234, 0, 32'h0,        0, 4'b0000, 32'h0,  32'h0,        32'h0,        1);
        do_req("dword_on_32",  0, 2'd3, 1'b0, 32'h08, 32'h0,        0, 32'h0,        0, 4'b0000, 32'h0,  32'h0,        32'h0,        1);
        test_flush();
        test_flush_with_ack();
        test_reset_mid();
        do_req("after_reset",  0, 2'd2, 1'b0, 32'h30, 32'h0,        0, 32'h87654321, 0, 4'b0000, 32'h30, 32'h0,        32'h87654321, 0);
        do_req64("dword64", 0, 2'd3, 1'b0, 32'h08, 64'h0, 64'h8000000000000001, 8'h00, 32'h08, 64'h0, 64'h8000000000000001);
        do_req64("word64_s", 0, 2'd2, 1'b0, 32'h0C, 64'h0, 64'h0000000080000001, 8'h00, 32'h08, 64'h0, 64'hFFFFFFFF80000001);
        do_req64("store_w64", 1, 2'd2, 1'b0, 32'h14, 64'h12345678, 64'h0, 8'h0F, 32'h10, 64'h1234567812345678, 64'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, data-bus width in bits; legal values 32 and 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Derived constant NB = DATA_W/8, the byte-lane count.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 req_valid  in  1  pipeline memory-stage request.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when DATA_W=64).
REQ-009 req_unsigned  in  1  zero-extend the load when 1; sign-extend when 0.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  DATA_W  store data, right-aligned.
REQ-012 req_ready  out  1  high only in IDLE.
REQ-013 flush  in  1  cancel the in-flight request.
REQ-014 mem_req  out  1  memory access strobe.
REQ-015 mem_be  out  NB  byte write strobes; all zero for loads.
REQ-016 mem_addr  out  ADDR_W  address aligned down to NB.
REQ-017 mem_wdata  out  DATA_W  lane-replicated store data.
REQ-018 mem_ack  in  1  memory done; for loads, mem_rdata is valid in the same cycle.
REQ-019 mem_rdata  in  DATA_W  read data.
REQ-020 resp_valid  out  1  one-cycle completion pulse.
REQ-021 resp_data  out  DATA_W  extended load result; zero for stores.
REQ-022 resp_err  out  1  misaligned or illegal size; qualified by resp_valid.
REQ-023 stall  out  1  pipeline stall while a request is outstanding.

Function
REQ-024 FSM states: IDLE, ISSUE, WAIT, DRAIN, RESP.
REQ-025 IDLE: if req_valid, register all req_* fields. If the request is misaligned (address not a multiple of the access size) or the size is illegal, go to RESP with err=1. Otherwise go to ISSUE.
REQ-026 ISSUE/WAIT: hold mem_req=1 with stable mem_addr, mem_be and mem_wdata until mem_ack.
REQ-027 ISSUE moves to WAIT after one cycle without ack. An ack in ISSUE or WAIT moves the FSM to RESP.
REQ-028 Lane mapping is big-endian: byte offset k drives data bits [DATA_W-1-8k -: 8] and strobe bit NB-1-k.
REQ-029 Store byte: replicate wdata[7:0] NB times. Store half: replicate wdata[15:0]. Store word on a 64-bit bus: replicate wdata[31:0].
REQ-030 Load: on ack, select the addressed lane of mem_rdata, extend it per req_unsigned, and register the result into resp_data.
REQ-031 RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
REQ-032 Minimum latency: request accepted at cycle T, ack at T+1, resp_valid at T+2.
REQ-033 stall = req_valid & ~req_ready, combinational.
REQ-034 flush in ISSUE/WAIT: go to DRAIN, or to IDLE if ack arrives in the same cycle. No resp_valid is produced.
REQ-035 flush in IDLE or RESP is ignored.
REQ-036 DRAIN: mem_req=0; wait for mem_ack, then go to IDLE. No response is produced.
REQ-037 A misaligned request never asserts mem_req.

Reset
REQ-038 Reset state is IDLE, with the following outputs: req_ready=1, mem_req=0, mem_be=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_data=0, resp_err=0.
REQ-039 Reset asserted mid-transaction abandons the transaction without waiting for ack. A later stray mem_ack in IDLE is ignored.

Structure
REQ-040 The shared package holds the size encodings, the FSM state enum, and the NB function.
REQ-041 A single sub-module, lane_extract, performs the combinational lane select and extension for loads. It is parametrised by DATA_W.

Verification
REQ-042 DATA_W=32, store byte, addr 0x13, wdata 0xA5, ack at T+1 -> mem_be=0001, mem_wdata=0xA5A5A5A5, mem_addr=0x10, resp_valid at T+2.
REQ-043 Load half signed, addr 0x22, mem_rdata=0x1234_F00D -> resp_data=0xFFFF_F00D. The same access unsigned -> 0x0000_F00D.
REQ-044 Load word, addr 0x02 -> resp_valid with resp_err=1 one cycle later; mem_req never asserted.
REQ-045 Load with ack delayed 5 cycles -> stall=1 throughout, mem_req held, resp_valid 1 cycle after ack.
REQ-046 flush 2 cycles into WAIT, ack 3 cycles later -> no resp_valid; req_ready returns the cycle after ack.
REQ-047 DATA_W=64, load dword, addr 0x08, rdata 0x8000_0000_0000_0001 -> resp_data equal to rdata. Dword at DATA_W=32 -> resp_err=1.
